// File: rtl/bpug_loader.sv
// Loads 56 weight bytes and 7 image bytes from byte memory into one BPU group,
// then issues a compute opcode for a programmed number of cycles.
module bpug_loader #(
  parameter int N_GROUPS  = 4,
  parameter int GRP_W     = 2,
  parameter int ADDR_W    = 10,
  parameter int WGT_BYTES = 56,
  parameter int IMG_BYTES = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [GRP_W-1:0]    grp,
  input  logic [ADDR_W-1:0]   wgt_base,
  input  logic [ADDR_W-1:0]   img_base,
  input  logic [4:0]          op,
  input  logic                op_dsel,
  input  logic [7:0]          op_cycles,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [7:0]          mem_rdata,
  output logic [7:0]          data_out,
  output logic [7:0]          instr_out,
  output logic [N_GROUPS-1:0] sel_out,
  output logic                busy,
  output logic                done
);

  // state  | meaning
  // IDLE   | waiting for start
  // LOAD_W | issuing weight byte reads
  // LOAD_I | issuing image byte reads
  // EXEC   | draining last image beat, then issuing compute cycles
  // FIN    | done pulse
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_I, EXEC, FIN} state_t;

  localparam int IDX_W = $clog2(WGT_BYTES);

  state_t              state;
  logic [GRP_W-1:0]    grp_q;
  logic [ADDR_W-1:0]   img_q;
  logic [4:0]          op_q;
  logic                dsel_q;
  logic [7:0]          cyc_q;
  logic [7:0]          cnt;
  logic [IDX_W-1:0]    idx;
  logic                rd_img;
  logic                beat_v;

  function automatic logic [N_GROUPS-1:0] onehot(input logic [GRP_W-1:0] g);
    logic [N_GROUPS-1:0] v;
    v = '0;
    for (int i = 0; i < N_GROUPS; i++)
      if (int'(g) == i) v[i] = 1'b1;
    return v;
  endfunction

  // Read data arrives the cycle after the strobe; it is forwarded on the beat
  // flagged by the registered read strobe so it lands on the bus in t+1.
  assign data_out = beat_v ? mem_rdata : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grp_q     <= '0;
      img_q     <= '0;
      op_q      <= '0;
      dsel_q    <= 1'b0;
      cyc_q     <= '0;
      cnt       <= '0;
      idx       <= '0;
      rd_img    <= 1'b0;
      beat_v    <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      instr_out <= '0;
      sel_out   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      beat_v <= mem_rd;
      done   <= 1'b0;
      if (mem_rd) begin
        instr_out <= rd_img ? 8'h80 : 8'h40;
        sel_out   <= onehot(grp_q);
      end else begin
        instr_out <= '0;
        sel_out   <= '0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            grp_q    <= grp;
            img_q    <= img_base;
            op_q     <= op;
            dsel_q   <= op_dsel;
            cyc_q    <= op_cycles;
            mem_rd   <= 1'b1;
            mem_addr <= wgt_base;
            rd_img   <= 1'b0;
            idx      <= '0;
            busy     <= 1'b1;
            state    <= LOAD_W;
          end
        end
        LOAD_W: begin
          if (idx == IDX_W'(WGT_BYTES - 1)) begin
            mem_addr <= img_q;
            rd_img   <= 1'b1;
            idx      <= '0;
            state    <= LOAD_I;
          end else begin
            mem_addr <= mem_addr + ADDR_W'(1);
            idx      <= idx + IDX_W'(1);
          end
        end
        LOAD_I: begin
          if (idx == IDX_W'(IMG_BYTES - 1)) begin
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            rd_img   <= 1'b0;
            idx      <= '0;
            cnt      <= cyc_q;
            state    <= EXEC;
          end else begin
            mem_addr <= mem_addr + ADDR_W'(1);
            idx      <= idx + IDX_W'(1);
          end
        end
        EXEC: begin
          if (cnt == 8'd0) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            instr_out <= {2'b00, dsel_q, op_q};
            sel_out   <= onehot(grp_q);
            cnt       <= cnt - 8'd1;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
